pe_fc_top: RTL and testbench

//  Streaming fully-connected classifier PE: consumes a 26x26 8-bit image one row (26 pixels) per en,

---
 rtl/pe_fc_pkg.sv | 43 ++++
 rtl/pe_fc_if.sv | 23 ++
 rtl/pe_fc_mac4.sv | 21 ++
 rtl/pe_fc_top.sv | 167 ++++++++++++++++
 tb/tb_pe_fc_top.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pe_fc_pkg.sv
// Shared sizes, FSM encoding and ROM address mapping for the fully-connected classifier PE.
// Weight ROM layout is class-major, then row, then 4-lane word within the row.
package pe_fc_pkg;

    localparam int PIX_W   = 8;
    localparam int ROW_PIX = 26;
    localparam int ROWS    = 26;
    localparam int NCLS    = 10;
    localparam int ACC_W   = 32;
    localparam int WPR     = (ROW_PIX + 3) / 4;

    localparam int DATA_W  = ROW_PIX * PIX_W;
    localparam int WORD_W  = 4 * PIX_W;
    localparam int ADDR_W  = 16;
    localparam int RES_W   = 5;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int CLS_W   = $clog2(NCLS);
    localparam int WRD_W   = $clog2(WPR);
    // 17-bit signed lane products, four of them summed
    localparam int SUM_W   = 2 * PIX_W + 3;
    localparam int PAD_W   = WPR * WORD_W - DATA_W;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NCLS - 1);
    localparam logic [WRD_W-1:0] WRD_LAST = WRD_W'(WPR - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_ARGMAX,
        ST_DONE
    } state_e;

    function automatic logic [ADDR_W-1:0] weight_addr(
        input logic [CLS_W-1:0] c,
        input logic [ROW_W-1:0] r,
        input logic [WRD_W-1:0] w
    );
        return ADDR_W'(32'(c) * 32'(ROWS * WPR) + 32'(r) * 32'(WPR) + 32'(w));
    endfunction

endpackage

// File: rtl/pe_fc_if.sv
// Row input, weight ROM port and result output of the classifier PE.
// master = surrounding system (deserializer, ROM, sink); slave = the PE.
interface pe_fc_if;
    import pe_fc_pkg::*;

    logic                en;
    logic [DATA_W-1:0]   parallel_data;
    logic [ADDR_W-1:0]   o_fc_weight_addr;
    logic [WORD_W-1:0]   i_fc_weight;
    logic [RES_W-1:0]    o_result_data;
    logic                o_result_data_valid;

    modport master (
        output en, parallel_data, i_fc_weight,
        input  o_fc_weight_addr, o_result_data, o_result_data_valid
    );

    modport slave (
        input  en, parallel_data, i_fc_weight,
        output o_fc_weight_addr, o_result_data, o_result_data_valid
    );

endinterface

// File: rtl/pe_fc_mac4.sv
// 4-lane dot product: unsigned pixels times signed weights, summed; combinational, no latency.
// Lanes beyond the row are fed zero pixels by the caller, so they contribute nothing.
module pe_fc_mac4
    import pe_fc_pkg::*;
(
    input  logic [WORD_W-1:0]        pix_i,
    input  logic [WORD_W-1:0]        wt_i,
    output logic signed [SUM_W-1:0]  sum_o
);

    localparam int PROD_W = 2 * PIX_W + 1;

    logic signed [PROD_W-1:0] prod [4];

    for (genvar j = 0; j < 4; j++) begin : g_lane
        assign prod[j] = $signed({1'b0, pix_i[j*PIX_W +: PIX_W]}) * $signed(wt_i[j*PIX_W +: PIX_W]);
    end

    assign sum_o = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]) + SUM_W'(prod[3]);

endmodule

// File: rtl/pe_fc_top.sv
// Streaming FC classifier: one row per en, 70 ROM fetches per row, argmax after row 25.
// Result valid 82 cycles after the last row is accepted; no backpressure, en ignored while busy.
module pe_fc_top
    import pe_fc_pkg::*;
(
    input  logic    PE_clk,
    input  logic    rst,
    pe_fc_if.slave  bus
);

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [CLS_W-1:0]         cls_q, cls_d;
    logic [WRD_W-1:0]         wrd_q, wrd_d;
    logic [DATA_W-1:0]        pix_q, pix_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;

    logic                     mac_vld_q, mac_vld_d;
    logic [CLS_W-1:0]         mac_cls_q, mac_cls_d;
    logic [WRD_W-1:0]         mac_wrd_q, mac_wrd_d;

    logic signed [ACC_W-1:0]  acc_q [NCLS];
    logic signed [ACC_W-1:0]  acc_d [NCLS];
    logic signed [ACC_W-1:0]  best_val_q, best_val_d;
    logic [RES_W-1:0]         best_idx_q, best_idx_d;
    logic [RES_W-1:0]         res_q, res_d;
    logic                     res_vld_q, res_vld_d;

    logic [WPR*WORD_W-1:0]    pix_pad;
    logic [WORD_W-1:0]        lane_pix;
    logic signed [SUM_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  mac_ext;
    logic                     fetch_last;

    // Zero padding past pixel 25 makes the unused lanes of the last word drop out
    assign pix_pad  = {{PAD_W{1'b0}}, pix_q};
    assign lane_pix = pix_pad[32'(mac_wrd_q) * WORD_W +: WORD_W];

    pe_fc_mac4 u_mac4 (
        .pix_i (lane_pix),
        .wt_i  (bus.i_fc_weight),
        .sum_o (mac_sum)
    );

    assign mac_ext    = {{(ACC_W - SUM_W){mac_sum[SUM_W-1]}}, mac_sum};
    assign fetch_last = (cls_q == CLS_LAST) && (wrd_q == WRD_LAST);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cls_d      = cls_q;
        wrd_d      = wrd_q;
        pix_d      = pix_q;
        addr_d     = addr_q;
        mac_vld_d  = 1'b0;
        mac_cls_d  = mac_cls_q;
        mac_wrd_d  = mac_wrd_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        res_d      = res_q;
        res_vld_d  = 1'b0;
        acc_d      = acc_q;

        // ROM data for the address issued last cycle is on i_fc_weight now
        if (mac_vld_q) begin
            acc_d[mac_cls_q] = acc_q[mac_cls_q] + mac_ext;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    pix_d   = bus.parallel_data;
                    cls_d   = '0;
                    wrd_d   = '0;
                    addr_d  = weight_addr('0, row_q, '0);
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mac_vld_d = 1'b1;
                mac_cls_d = cls_q;
                mac_wrd_d = wrd_q;
                if (fetch_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    if (wrd_q == WRD_LAST) begin
                        wrd_d = '0;
                        cls_d = cls_q + 1'b1;
                    end else begin
                        wrd_d = wrd_q + 1'b1;
                    end
                    addr_d = weight_addr(cls_d, row_q, wrd_d);
                end
            end
            ST_DRAIN: begin
                if (row_q == ROW_LAST) begin
                    cls_d   = '0;
                    state_d = ST_ARGMAX;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ARGMAX: begin
                // Strict compare keeps the lowest index on ties
                if ((cls_q == '0) || (acc_q[cls_q] > best_val_q)) begin
                    best_val_d = acc_q[cls_q];
                    best_idx_d = RES_W'(cls_q);
                end
                if (cls_q == CLS_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cls_d = cls_q + 1'b1;
                end
            end
            ST_DONE: begin
                res_d     = best_idx_q;
                res_vld_d = 1'b1;
                row_d     = '0;
                acc_d     = '{default: '0};
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PE_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            cls_q      <= '0;
            wrd_q      <= '0;
            pix_q      <= '0;
            addr_q     <= '0;
            mac_vld_q  <= 1'b0;
            mac_cls_q  <= '0;
            mac_wrd_q  <= '0;
            acc_q      <= '{default: '0};
            best_val_q <= '0;
            best_idx_q <= '0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cls_q      <= cls_d;
            wrd_q      <= wrd_d;
            pix_q      <= pix_d;
            addr_q     <= addr_d;
            mac_vld_q  <= mac_vld_d;
            mac_cls_q  <= mac_cls_d;
            mac_wrd_q  <= mac_wrd_d;
            acc_q      <= acc_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            res_q      <= res_d;
            res_vld_q  <= res_vld_d;
        end
    end

    assign bus.o_fc_weight_addr    = addr_q;
    assign bus.o_result_data       = res_q;
    assign bus.o_result_data_valid = res_vld_q;

endmodule

// File: tb/tb_pe_fc_top.sv
// Bench for pe_fc_top: random and directed frames scored by a plain-arithmetic classifier model.
`timescale 1ns/1ps
module tb_pe_fc_top;
    import pe_fc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nchecks = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_fc_if bus ();

    pe_fc_top dut (
        .PE_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    // Weight ROM with one-cycle synchronous read
    logic [WORD_W-1:0] rom [0:65535];
    always @(posedge clk) bus.i_fc_weight <= rom[bus.o_fc_weight_addr];

    typedef struct { int due; int val; } exp_t;
    exp_t   addr_exp[$];
    exp_t   res_exp[$];
    longint score [NCLS];
    int     mrow;
    int     next_ok;

    task automatic check(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (addr_exp.size() > 0 && addr_exp[0].due == cyc) begin
                e = addr_exp.pop_front();
                check("weight_addr", longint'(bus.o_fc_weight_addr), longint'(e.val));
            end
            if (bus.o_result_data_valid) begin
                if (res_exp.size() == 0) begin
                    check("valid_unexpected", longint'(bus.o_result_data_valid), 0);
                end else begin
                    e = res_exp.pop_front();
                    check("result_class", longint'(bus.o_result_data), longint'(e.val));
                    check("result_latency", longint'(cyc), longint'(e.due));
                end
            end else if (res_exp.size() > 0 && res_exp[0].due < cyc) begin
                e = res_exp.pop_front();
                check("valid_missing", longint'(bus.o_result_data_valid), 1);
            end
        end
    end

    task automatic fill_rom(input int mode);
        int v;
        logic [WORD_W-1:0] word;
        for (int c = 0; c < NCLS; c++)
            for (int r = 0; r < ROWS; r++)
                for (int w = 0; w < WPR; w++) begin
                    word = '0;
                    for (int j = 0; j < 4; j++) begin
                        case (mode)
                            0: v = int'($urandom_range(0, 255));
                            1: v = (c == 3) ? 1 : 0;
                            2: v = 0;
                            3: v = ((c == 2 || c == 7) && r == 0 && w == 0 && j == 0) ? 5 : 0;
                            default: begin
                                if (c == 0)
                                    v = -1;
                                else if (c == 9)
                                    v = (w == WPR - 1 && j >= 2) ? 127 :
                                        ((r == 0 && w == 0 && j == 0) ? -2 : -1);
                                else
                                    v = -128;
                            end
                        endcase
                        word[8*j +: 8] = v[7:0];
                    end
                    rom[c*ROWS*WPR + r*WPR + w] = word;
                end
    endtask

    function automatic logic [DATA_W-1:0] make_row(input int mode);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < ROW_PIX; k++) begin
            case (mode)
                1:       d[8*k +: 8] = 8'd1;
                2:       d[8*k +: 8] = 8'd255;
                default: d[8*k +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return d;
    endfunction

    // Reference: score[c] = sum over accepted rows and pixels of pix * signed weight
    task automatic model_accept(input logic [DATA_W-1:0] d, input int a);
        logic [WORD_W-1:0] word;
        logic signed [7:0] wb;
        int best;
        for (int c = 0; c < NCLS; c++)
            for (int w = 0; w < WPR; w++)
                addr_exp.push_back('{a + c*WPR + w, c*ROWS*WPR + mrow*WPR + w});
        addr_exp.push_back('{a + NCLS*WPR,     (NCLS-1)*ROWS*WPR + mrow*WPR + WPR - 1});
        addr_exp.push_back('{a + NCLS*WPR + 1, (NCLS-1)*ROWS*WPR + mrow*WPR + WPR - 1});
        for (int c = 0; c < NCLS; c++)
            for (int k = 0; k < ROW_PIX; k++) begin
                word = rom[c*ROWS*WPR + mrow*WPR + k/4];
                wb   = word[8*(k%4) +: 8];
                score[c] += longint'(d[8*k +: 8]) * longint'(wb);
            end
        mrow++;
        if (mrow == ROWS) begin
            best = 0;
            for (int c = 1; c < NCLS; c++)
                if (score[c] > score[best]) best = c;
            res_exp.push_back('{a + 82, best});
            for (int c = 0; c < NCLS; c++) score[c] = 0;
            mrow    = 0;
            next_ok = a + 83;
        end else begin
            next_ok = a + 72;
        end
    endtask

    task automatic wait_idle();
        while (cyc < next_ok) @(negedge clk);
    endtask

    task automatic send_row(input logic [DATA_W-1:0] d);
        @(negedge clk);
        while (cyc + 1 < next_ok) @(negedge clk);
        bus.en            = 1'b1;
        bus.parallel_data = d;
        model_accept(d, cyc + 1);
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic run_frame(input int rom_mode, input int pix_mode);
        wait_idle();
        fill_rom(rom_mode);
        for (int r = 0; r < ROWS; r++) send_row(make_row(pix_mode));
    endtask

    task automatic reset_midframe();
        wait_idle();
        fill_rom(0);
        for (int r = 0; r < 6; r++) send_row(make_row(0));
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_addr",   longint'(bus.o_fc_weight_addr), 0);
        check("rst_result", longint'(bus.o_result_data), 0);
        check("rst_valid",  longint'(bus.o_result_data_valid), 0);
        addr_exp.delete();
        res_exp.delete();
        for (int c = 0; c < NCLS; c++) score[c] = 0;
        mrow = 0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        next_ok = cyc + 1;
    endtask

    task automatic held_frame();
        logic [DATA_W-1:0] d;
        int n;
        n = 0;
        wait_idle();
        fill_rom(0);
        for (int i = 0; i < 4000 && n < ROWS; i++) begin
            @(negedge clk);
            d                 = make_row(0);
            bus.en            = 1'b1;
            bus.parallel_data = d;
            if (cyc + 1 >= next_ok) begin
                model_accept(d, cyc + 1);
                n++;
            end
        end
        @(negedge clk);
        bus.en = 1'b0;
        check("held_rows_accepted", longint'(n), longint'(ROWS));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.en            = 1'b0;
        bus.parallel_data = '0;
        mrow              = 0;
        next_ok           = 0;
        for (int c = 0; c < NCLS; c++) score[c] = 0;
        for (int i = 0; i < 65536; i++) rom[i] = '0;

        repeat (3) @(negedge clk);
        check("reset_addr",   longint'(bus.o_fc_weight_addr), 0);
        check("reset_result", longint'(bus.o_result_data), 0);
        check("reset_valid",  longint'(bus.o_result_data_valid), 0);
        @(negedge clk);
        rst     = 1'b0;
        next_ok = cyc + 1;

        run_frame(1, 1);   // only class 3 has nonzero weights
        reset_midframe();
        run_frame(0, 0);   // full random frame straight after the abort
        run_frame(2, 0);   // all-zero weights
        run_frame(3, 1);   // classes 2 and 7 tie
        run_frame(4, 2);   // negative weights, class 9 padding lanes large
        run_frame(0, 0);
        held_frame();

        for (int i = 0; i < 300 && (res_exp.size() > 0 || addr_exp.size() > 0); i++)
            @(negedge clk);
        check("pending_results", longint'(res_exp.size()), 0);
        check("pending_addrs",   longint'(addr_exp.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
